// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: turns host configuration words into a serial bit stream
// for a ccff scan chain. It can optionally run a readback pass afterwards, in
// which the host resends the same stream and the chain tail is compared bit
// by bit against the head.
//
// Ports:
//   prog_clk   configuration clock; all state changes on the rising edge
//   pReset     asynchronous active-high reset
//   start      single-cycle session request, honoured only in IDLE
//   verify     sampled with start; 1 adds a readback-check pass
//   s_valid    host word valid
//   s_data     host word, shifted out MSB first
//   s_ready    loader can accept a word this cycle
//   ccff_head  serial data into the chain head (registered)
//   ccff_en    chain shift enable (registered)
//   ccff_tail  serial data from the chain tail
//   busy       session in progress (LOAD, CHECK, FINISH)
//   done       one-cycle pulse in FINISH
//   error      sticky readback mismatch flag
//   bit_count  bits shifted in the current pass
module ccff_chain_loader #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CHAIN_LEN = 20,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int unsigned      PEND_W   = $clog2(DATA_W + 1);
  localparam logic [CNT_W:0]   LEN_X    = (CNT_W + 1)'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [PEND_W-1:0] PEND_LOAD = PEND_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, FINISH} state_t;

  state_t              state;
  logic                verify_q;
  logic [DATA_W-1:0]   shreg;    // bits not yet driven, aligned to the MSB
  logic [PEND_W-1:0]   pend;     // count of bits still waiting in shreg

  logic                active;
  logic [CNT_W:0]      issued;
  logic                room;
  logic                accept;
  logic                pass_end;

  always_comb begin
    active   = (state == LOAD) || (state == CHECK);
    // Bits committed to the chain, including the one on ccff_head right now.
    // Gating on this, not just bit_count, keeps a word from being swallowed
    // on the final shift cycle of a pass.
    issued   = {1'b0, bit_count} + {{CNT_W{1'b0}}, ccff_en};
    room     = issued < LEN_X;
    s_ready  = active && (pend == '0) && room;
    accept   = s_ready && s_valid;
    pass_end = active && ccff_en && (bit_count == LAST_CNT);
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state     <= IDLE;
      verify_q  <= 1'b0;
      shreg     <= '0;
      pend      <= '0;
      ccff_head <= 1'b0;
      ccff_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      bit_count <= '0;
    end else begin
      done    <= 1'b0;
      ccff_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            busy      <= 1'b1;
            verify_q  <= verify;
            bit_count <= '0;
            error     <= 1'b0;
          end
        end
        LOAD, CHECK: begin
          if (ccff_en && (bit_count != LEN_C)) begin
            bit_count <= bit_count + 1'b1;
          end
          if ((state == CHECK) && ccff_en && (ccff_tail != ccff_head)) begin
            error <= 1'b1;
          end
          // The MSB goes out on the acceptance edge, so a word occupies the
          // DATA_W cycles immediately after it is accepted.
          if (accept) begin
            ccff_head <= s_data[DATA_W-1];
            ccff_en   <= 1'b1;
            shreg     <= s_data << 1;
            pend      <= PEND_LOAD;
          end else if (pend != '0) begin
            if (room) begin
              ccff_head <= shreg[DATA_W-1];
              ccff_en   <= 1'b1;
              shreg     <= shreg << 1;
              pend      <= pend - 1'b1;
            end else begin
              // Chain full: drop the rest of the word.
              pend <= '0;
            end
          end
          if (pass_end) begin
            if ((state == LOAD) && verify_q) begin
              state     <= CHECK;
              bit_count <= '0;
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
